// File: rtl/dac_spi_timing.sv
// Frame timing generator for the DAC serial driver: en_dac, cs, sck and bit index.
// Optional build macro PERIODIC_TRIG_EN adds an internal periodic trigger with a one-deep pending flag.
module dac_spi_timing #(
    parameter int SCK_DIV       = 2,
    parameter int FRAME_BITS    = 16,
    parameter int CS_SETUP      = 2,
    parameter int CS_HOLD       = 2,
    parameter int FRAME_GAP     = 12,
    parameter int UPDATE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_state,
    input  logic       start,
    output logic       en_dac,
    output logic       cs,
    output logic       sck,
    output logic [4:0] cnt_sck,
    output logic       busy,
    output logic       frame_done
);

    localparam int TMAX1  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TMR_MX = (TMAX1 > FRAME_GAP) ? TMAX1 : FRAME_GAP;
    localparam int TMR_W  = $clog2(TMR_MX + 1);
    localparam int PH_W   = $clog2(SCK_DIV);

    if (SCK_DIV < 2 || FRAME_GAP < 10 || FRAME_BITS > 31 || UPDATE_PERIOD < 2) begin : g_param_chk
        $error("dac_spi_timing: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              sck_d;
    logic [4:0]        cnt_d;
    logic              launch;
    logic              phase_wrap;

`ifdef PERIODIC_TRIG_EN
    localparam int PER_W = $clog2(UPDATE_PERIOD);
    logic [PER_W-1:0] per_cnt;
    logic             per_trig;
    logic             trig;
    logic             pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            per_cnt <= '0;
        else if (!key_state || per_trig)
            per_cnt <= '0;
        else
            per_cnt <= per_cnt + 1'b1;
    end

    assign per_trig = key_state && (per_cnt == PER_W'(UPDATE_PERIOD - 1));
    assign trig     = start || per_trig;
    assign launch   = trig || pending;

    // A trigger that lands while a frame is in flight is remembered once; extras are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 1'b0;
        else if (!key_state)
            pending <= 1'b0;
        else if (state_q == IDLE && state_d == START)
            pending <= 1'b0;
        else if (trig && state_q != IDLE)
            pending <= 1'b1;
    end
`else
    assign launch = start;
`endif

    assign phase_wrap = (phase_q == PH_W'(SCK_DIV - 1));

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (!key_state) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (launch) state_d = START;
                START: state_d = SETUP;
                SETUP: if (tmr_q == TMR_W'(CS_SETUP - 1)) state_d = SHIFT;
                SHIFT: if (phase_wrap && sck && cnt_sck == 5'(FRAME_BITS - 1)) state_d = HOLD;
                HOLD:  if (tmr_q == TMR_W'(CS_HOLD - 1)) state_d = GAP;
                GAP:   if (tmr_q == TMR_W'(FRAME_GAP - 1)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, derived from the state being entered.
    always_comb begin
        tmr_d   = '0;
        phase_d = '0;
        sck_d   = 1'b0;
        cnt_d   = '0;
        if (state_d == state_q && (state_q == SETUP || state_q == HOLD || state_q == GAP))
            tmr_d = tmr_q + 1'b1;
        if (state_d == SHIFT && state_q == SHIFT) begin
            phase_d = phase_wrap ? '0 : phase_q + 1'b1;
            sck_d   = phase_wrap ? ~sck : sck;
            cnt_d   = (phase_wrap && sck) ? cnt_sck + 1'b1 : cnt_sck;
        end
        if (state_d == HOLD)
            cnt_d = 5'(FRAME_BITS);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            phase_q    <= '0;
            en_dac     <= 1'b0;
            cs         <= 1'b1;
            sck        <= 1'b0;
            cnt_sck    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            phase_q    <= phase_d;
            en_dac     <= (state_d == START);
            cs         <= !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
            sck        <= sck_d;
            cnt_sck    <= cnt_d;
            busy       <= (state_d != IDLE);
            frame_done <= (state_d == GAP) && (tmr_d == TMR_W'(FRAME_GAP - 1));
        end
    end

endmodule

// File: tb/tb_dac_spi_timing.sv
// Self-checking bench for dac_spi_timing: two instances (SCK_DIV=2 and 4) against a frame-position model.
module tb_dac_spi_timing;

    localparam int FRAME_BITS = 16;
    localparam int CS_SETUP   = 2;
    localparam int CS_HOLD    = 2;
    localparam int FRAME_GAP  = 12;
    localparam int LEN2 = 1 + CS_SETUP + 2 * 2 * FRAME_BITS + CS_HOLD + FRAME_GAP;
    localparam int LEN4 = 1 + CS_SETUP + 2 * 4 * FRAME_BITS + CS_HOLD + FRAME_GAP;

    logic clk, rst, key_state, start;
    logic en2, cs2, sck2, busy2, fd2;
    logic en4, cs4, sck4, busy4, fd4;
    logic [4:0] cnt2, cnt4;

    int n_checks = 0;
    int n_pass   = 0;
    int pos2 = -1;
    int pos4 = -1;
    int en_cnt, rise_cnt, fd_cnt;
    logic sck2_prev = 1'b0;

    dac_spi_timing #(.SCK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .key_state(key_state), .start(start),
        .en_dac(en2), .cs(cs2), .sck(sck2), .cnt_sck(cnt2), .busy(busy2), .frame_done(fd2)
    );

    dac_spi_timing #(.SCK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .key_state(key_state), .start(start),
        .en_dac(en4), .cs(cs4), .sck(sck4), .cnt_sck(cnt4), .busy(busy4), .frame_done(fd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] mk(logic en, logic c, logic s, int n, logic b, logic f);
        return {en, c, s, 5'(n), b, f};
    endfunction

    // Expected outputs at position p (cycles since the en_dac cycle; negative = idle).
    function automatic logic [9:0] model_out(int p, int div);
        int sh0, sh1, gp0, len, s;
        sh0 = 1 + CS_SETUP;
        sh1 = sh0 + 2 * div * FRAME_BITS;
        gp0 = sh1 + CS_HOLD;
        len = gp0 + FRAME_GAP;
        if (p < 0)    return mk(0, 1, 0, 0, 0, 0);
        if (p == 0)   return mk(1, 1, 0, 0, 1, 0);
        if (p < sh0)  return mk(0, 0, 0, 0, 1, 0);
        if (p < sh1) begin
            s = p - sh0;
            return mk(0, 0, (s % (2 * div)) >= div, s / (2 * div), 1, 0);
        end
        if (p < gp0)  return mk(0, 0, 0, FRAME_BITS, 1, 0);
        return mk(0, 1, 0, 0, 1, p == len - 1);
    endfunction

    function automatic int next_pos(int p, logic s, logic k, int len);
        if (!k)         return -1;
        if (p < 0)      return s ? 0 : -1;
        if (p + 1 >= len) return -1;
        return p + 1;
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
    endtask

    // Drive inputs for one edge, advance the model, then compare both instances mid-cycle.
    task automatic step(input logic s, input logic k);
        start = s;
        key_state = k;
        @(posedge clk);
        pos2 = next_pos(pos2, s, k, LEN2);
        pos4 = next_pos(pos4, s, k, LEN4);
        @(negedge clk);
        check("model_div2", {en2, cs2, sck2, cnt2, busy2, fd2}, model_out(pos2, 2));
        check("model_div4", {en4, cs4, sck4, cnt4, busy4, fd4}, model_out(pos4, 4));
        if (en2) en_cnt++;
        if (fd2) fd_cnt++;
        if (sck2 && !sck2_prev) rise_cnt++;
        sck2_prev = sck2;
    endtask

    task automatic clear_counts();
        en_cnt = 0;
        rise_cnt = 0;
        fd_cnt = 0;
    endtask

    typedef struct {
        logic       start;
        logic       key;
        int         n;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;

        tbl[0]  = '{1'b1, 1'b1, 1,  mk(1, 1, 0, 0,  1, 0)};
        tbl[1]  = '{1'b0, 1'b1, 1,  mk(0, 0, 0, 0,  1, 0)};
        tbl[2]  = '{1'b0, 1'b1, 2,  mk(0, 0, 0, 0,  1, 0)};
        tbl[3]  = '{1'b0, 1'b1, 2,  mk(0, 0, 1, 0,  1, 0)};
        tbl[4]  = '{1'b0, 1'b1, 2,  mk(0, 0, 0, 1,  1, 0)};
        tbl[5]  = '{1'b1, 1'b1, 1,  mk(0, 0, 0, 1,  1, 0)};
        tbl[6]  = '{1'b0, 1'b1, 59, mk(0, 0, 0, 16, 1, 0)};
        tbl[7]  = '{1'b0, 1'b1, 2,  mk(0, 1, 0, 0,  1, 0)};
        tbl[8]  = '{1'b0, 1'b1, 11, mk(0, 1, 0, 0,  1, 1)};
        tbl[9]  = '{1'b0, 1'b1, 1,  mk(0, 1, 0, 0,  0, 0)};
        tbl[10] = '{1'b1, 1'b0, 1,  mk(0, 1, 0, 0,  0, 0)};
        tbl[11] = '{1'b1, 1'b1, 1,  mk(1, 1, 0, 0,  1, 0)};
        tbl[12] = '{1'b0, 1'b0, 1,  mk(0, 1, 0, 0,  0, 0)};

        rst = 1'b1;
        start = 1'b0;
        key_state = 1'b0;
        clear_counts();
        #1;
        check("reset_div2", {en2, cs2, sck2, cnt2, busy2, fd2}, mk(0, 1, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b1);

        for (int i = 0; i < 13; i++) begin
            for (int j = 0; j < tbl[i].n; j++) step(tbl[i].start, tbl[i].key);
            check($sformatf("vec%0d", i), {en2, cs2, sck2, cnt2, busy2, fd2}, tbl[i].exp);
        end
        repeat (150) step(1'b0, 1'b1);

        // Extra start at T+30 must be ignored.
        clear_counts();
        step(1'b1, 1'b1);
        for (int i = 2; i <= 85; i++) step(i == 30, 1'b1);
        check_int("busy_start_en_dac", en_cnt, 1);
        check_int("busy_start_sck_pulses", rise_cnt, 16);
        check_int("busy_start_frame_done", fd_cnt, 1);
        repeat (70) step(1'b0, 1'b1);

        // Back-to-back: start in the first idle cycle after GAP.
        clear_counts();
        step(1'b1, 1'b1);
        repeat (LEN2) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("back_to_back_en", {en2, busy2}, 10'b11);
        repeat (LEN4 + 5) step(1'b0, 1'b1);
        check_int("back_to_back_en_count", en_cnt, 2);

        // key_state drop at cnt_sck=7 aborts without frame_done.
        clear_counts();
        step(1'b1, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            step(1'b0, 1'b1);
            if (cnt2 == 5'd7) reached = 1'b1;
        end
        check_int("key_drop_reach_cnt7", int'(reached), 1);
        step(1'b0, 1'b0);
        check("key_drop_idle", {en2, cs2, sck2, cnt2, busy2, fd2}, mk(0, 1, 0, 0, 0, 0));
        repeat (90) step(1'b0, 1'b1);
        check_int("key_drop_no_frame_done", fd_cnt, 0);
        clear_counts();
        step(1'b1, 1'b1);
        repeat (LEN2 + 2) step(1'b0, 1'b1);
        check_int("clean_frame_en", en_cnt, 1);
        check_int("clean_frame_sck", rise_cnt, 16);
        check_int("clean_frame_done", fd_cnt, 1);
        repeat (70) step(1'b0, 1'b1);

        // Asynchronous reset in the middle of SHIFT.
        step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        check_int("pre_reset_in_shift", int'(cs2 == 1'b0 && busy2), 1);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_div2", {en2, cs2, sck2, cnt2, busy2, fd2}, mk(0, 1, 0, 0, 0, 0));
        check("reset_mid_div4", {en4, cs4, sck4, cnt4, busy4, fd4}, mk(0, 1, 0, 0, 0, 0));
        pos2 = -1;
        pos4 = -1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step(1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 149) != 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
